// File: rtl/bcd_conv_arbiter.sv
// Shared binary-to-BCD converter for two requesters. Requesters are served round-robin, inputs
// are clamped to SAT_MAX, and conversion is double-dabble at one bit per clock.
module bcd_conv_arbiter #(
    parameter int unsigned WIDTH   = 14,
    parameter int unsigned SAT_MAX = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_thousands,
    output logic [3:0]       out_hundreds,
    output logic [3:0]       out_tens,
    output logic [3:0]       out_ones,
    output logic             out_tag,
    output logic             out_overflow,
    output logic [3:0]       out_blank
);

    localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] SatMax  = WIDTH'(SAT_MAX);
    localparam logic [CntW-1:0]  CntInit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] value_q;
    logic [15:0]      bcd_q;
    logic             tag_q;
    logic             ovf_q;

    logic             grant_any;
    logic             grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             grant_over;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_next;
    logic [3:0]       blank_next;

    // Round-robin: on a tie the requester that did not win last time is served.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_idx  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        grant_data = grant_idx ? req1_data : req0_data;
        grant_over = (grant_data > SatMax);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next      = {bcd_adj[14:0], value_q[WIDTH-1]};
        blank_next[3] = (bcd_next[15:12] == 4'd0);
        blank_next[2] = blank_next[3] && (bcd_next[11:8] == 4'd0);
        blank_next[1] = blank_next[2] && (bcd_next[7:4] == 4'd0);
        blank_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_any) state_d = StShift;
            StShift: if (cnt_q == '0) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Readies are suppressed during reset so no requester believes a discarded value was taken.
    always_comb begin
        req0_ready = (state_q == StIdle) && !reset && grant_any && !grant_idx;
        req1_ready = (state_q == StIdle) && !reset && grant_any && grant_idx;
        out_valid  = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            value_q       <= '0;
            bcd_q         <= '0;
            tag_q         <= 1'b0;
            ovf_q         <= 1'b0;
            out_thousands <= '0;
            out_hundreds  <= '0;
            out_tens      <= '0;
            out_ones      <= '0;
            out_tag       <= 1'b0;
            out_overflow  <= 1'b0;
            out_blank     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        value_q      <= grant_over ? SatMax : grant_data;
                        ovf_q        <= grant_over;
                        tag_q        <= grant_idx;
                        last_grant_q <= grant_idx;
                        bcd_q        <= '0;
                        cnt_q        <= CntInit;
                    end
                end
                StShift: begin
                    bcd_q   <= bcd_next;
                    value_q <= value_q << 1;
                    if (cnt_q == '0) begin
                        out_thousands <= bcd_next[15:12];
                        out_hundreds  <= bcd_next[11:8];
                        out_tens      <= bcd_next[7:4];
                        out_ones      <= bcd_next[3:0];
                        out_tag       <= tag_q;
                        out_overflow  <= ovf_q;
                        out_blank     <= blank_next;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus a randomized run scored against a
// decimal-arithmetic reference model.
module tb_bcd_conv_arbiter;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         out_valid, out_ready;
    logic [3:0]   out_thousands, out_hundreds, out_tens, out_ones;
    logic         out_tag, out_overflow;
    logic [3:0]   out_blank;

    int n_cmp = 0;
    int n_bad = 0;
    int corners[12] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.WIDTH(W), .SAT_MAX(9999)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_thousands(out_thousands), .out_hundreds(out_hundreds),
        .out_tens(out_tens), .out_ones(out_ones),
        .out_tag(out_tag), .out_overflow(out_overflow), .out_blank(out_blank)
    );

    function automatic logic [15:0] ref_bcd(input int v);
        int m;
        m = (v > 9999) ? 9999 : v;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [3:0] ref_blank(input int v);
        int m;
        m = (v > 9999) ? 9999 : v;
        return {m < 1000, m < 100, m < 10, 1'b0};
    endfunction

    function automatic int pick_value();
        if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 11)];
        return int'($urandom_range(0, 16383));
    endfunction

    function automatic logic [15:0] digits();
        return {out_thousands, out_hundreds, out_tens, out_ones};
    endfunction

    // Every step lands 2 time units after a rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    // Issues one value on requester n and returns what appears at the output; lat = -1 on timeout.
    task automatic run_one(input bit n, input int v, output int lat, output logic [15:0] dig,
                           output logic tg, output logic ov, output logic [3:0] bl);
        int k;
        lat = -1;
        out_ready = 1'b1;
        if (n) begin req1_valid = 1'b1; req1_data = W'(v); end
        else   begin req0_valid = 1'b1; req0_data = W'(v); end
        #1;
        k = 0;
        while (!(n ? req1_ready : req0_ready) && k < 50) begin cyc(); k++; end
        if (n ? req1_ready : req0_ready) begin
            cyc();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            k = 1;
            while (!out_valid && k < 50) begin cyc(); k++; end
            if (out_valid) lat = k;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        dig = digits();
        tg = out_tag;
        ov = out_overflow;
        bl = out_blank;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_data = W'(5);
        req1_valid = 1'b1; req1_data = W'(6);
        out_ready = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_handshake: got %b expected 000", {req0_ready, req1_ready, out_valid});
        end
        n_cmp++;
        if ({digits(), out_tag, out_overflow, out_blank} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b expected 0000/0/0/0000",
                     digits(), out_tag, out_overflow, out_blank);
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        int lat; logic [15:0] dig; logic tg, ov; logic [3:0] bl;
        do_reset();
        run_one(1'b0, 1234, lat, dig, tg, ov, bl);
        n_cmp++;
        if (lat !== 15) begin n_bad++; $display("FAIL single_latency: got %0d expected 15", lat); end
        n_cmp++;
        if ({dig, tg, ov, bl} !== {16'h1234, 1'b0, 1'b0, 4'b0000}) begin
            n_bad++;
            $display("FAIL single_result: got %h/%b/%b/%b expected 1234/0/0/0000", dig, tg, ov, bl);
        end
    endtask

    task automatic test_arbitration();
        int gtag[$]; int gcyc[$]; int rtag[$]; logic [15:0] rdig[$]; logic [3:0] rbl[$];
        bit dbl;
        dbl = 1'b0;
        do_reset();
        out_ready = 1'b1;
        req0_data = W'(42); req1_data = W'(7);
        req0_valid = 1'b1;  req1_valid = 1'b1;
        for (int c = 0; c < 200 && rtag.size() < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) dbl = 1'b1;
            if (req0_ready) begin gtag.push_back(0); gcyc.push_back(c); end
            if (req1_ready) begin gtag.push_back(1); gcyc.push_back(c); end
            if (out_valid) begin
                rtag.push_back(int'(out_tag)); rdig.push_back(digits()); rbl.push_back(out_blank);
            end
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_cmp++;
        if (dbl) begin n_bad++; $display("FAIL arb_one_ready: got two readies expected one"); end
        n_cmp++;
        if (rtag.size() < 4 || gcyc.size() < 4) begin
            n_bad++;
            $display("FAIL arb_count: got %0d results expected 4", rtag.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rtag[i] != i % 2 || rdig[i] !== ((i % 2) ? 16'h0007 : 16'h0042) ||
                    rbl[i] !== ((i % 2) ? 4'b1110 : 4'b1100)) begin
                    n_bad++;
                    $display("FAIL arb_result%0d: got tag %0d %h/%b expected tag %0d", i, rtag[i],
                             rdig[i], rbl[i], i % 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (gcyc[i+1] - gcyc[i] != W + 2) begin
                    n_bad++;
                    $display("FAIL arb_spacing%0d: got %0d expected %0d", i, gcyc[i+1] - gcyc[i],
                             W + 2);
                end
            end
        end
        cyc();
    endtask

    task automatic test_clamp();
        int lat; logic [15:0] dig; logic tg, ov; logic [3:0] bl;
        do_reset();
        run_one(1'b1, 16383, lat, dig, tg, ov, bl);
        n_cmp++;
        if ({lat == 15, dig, tg, ov, bl} !== {1'b1, 16'h9999, 1'b1, 1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL clamp_max: got lat %0d %h/%b/%b/%b expected 9999/1/1/0000",
                     lat, dig, tg, ov, bl);
        end
        run_one(1'b1, 9999, lat, dig, tg, ov, bl);
        n_cmp++;
        if ({dig, tg, ov} !== {16'h9999, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL clamp_edge: got %h/%b/%b expected 9999/1/0", dig, tg, ov);
        end
        run_one(1'b0, 0, lat, dig, tg, ov, bl);
        n_cmp++;
        if ({dig, ov, bl} !== {16'h0000, 1'b0, 4'b1110}) begin
            n_bad++;
            $display("FAIL clamp_zero: got %h/%b/%b expected 0000/0/1110", dig, ov, bl);
        end
    endtask

    task automatic test_backpressure();
        int k; bit stable; logic [15:0] s_dig; logic s_tag, s_ovf; logic [3:0] s_bl;
        do_reset();
        req0_valid = 1'b1; req0_data = W'(321);
        #1;
        k = 0;
        while (!req0_ready && k < 50) begin cyc(); k++; end
        cyc();
        req0_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin cyc(); k++; end
        s_dig = digits(); s_tag = out_tag; s_ovf = out_overflow; s_bl = out_blank;
        n_cmp++;
        if ({out_valid, s_dig, s_bl} !== {1'b1, 16'h0321, 4'b1000}) begin
            n_bad++;
            $display("FAIL bp_done: got valid %b %h/%b expected 1 0321/1000", out_valid, s_dig, s_bl);
        end
        req1_valid = 1'b1; req1_data = W'(55);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!out_valid || req0_ready || req1_ready || digits() !== s_dig ||
                out_tag !== s_tag || out_overflow !== s_ovf || out_blank !== s_bl) stable = 1'b0;
            cyc();
        end
        n_cmp++;
        if (!stable) begin n_bad++; $display("FAIL bp_hold: got changing outputs expected stable"); end
        out_ready = 1'b1;
        cyc();
        #1;
        n_cmp++;
        if ({out_valid, req1_ready, req0_ready} !== 3'b010) begin
            n_bad++;
            $display("FAIL bp_regrant: got %b expected 010", {out_valid, req1_ready, req0_ready});
        end
        cyc();
        req1_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin cyc(); k++; end
        n_cmp++;
        if ({out_valid, digits(), out_tag} !== {1'b1, 16'h0055, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_second: got %b %h tag %b expected 1 0055 tag 1", out_valid, digits(),
                     out_tag);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int k; bit quiet; int lat; logic [15:0] dig; logic tg, ov; logic [3:0] bl;
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = W'(777);
        #1;
        k = 0;
        while (!req0_ready && k < 50) begin cyc(); k++; end
        cyc();
        req0_valid = 1'b0;
        repeat (6) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid || digits() !== 16'h0000 || out_blank !== 4'b0000) quiet = 1'b0;
            cyc();
        end
        n_cmp++;
        if (!quiet) begin n_bad++; $display("FAIL mid_reset_quiet: got activity expected none"); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_reset_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        run_one(1'b0, 500, lat, dig, tg, ov, bl);
        n_cmp++;
        if ({lat == 15, dig, tg, bl} !== {1'b1, 16'h0500, 1'b0, 4'b1000}) begin
            n_bad++;
            $display("FAIL mid_reset_next: got lat %0d %h/%b/%b expected 15 0500/0/1000",
                     lat, dig, tg, bl);
        end
    endtask

    task automatic test_random();
        bit exp_tag[$]; int exp_val[$];
        int accepted, results, cycles, v; bit model_last, taken0, taken1, dbl, g, eg;
        accepted = 0; results = 0; cycles = 0;
        model_last = 1'b1; taken0 = 1'b0; taken1 = 1'b0; dbl = 1'b0;
        do_reset();
        while (cycles < 20000 &&
               !(accepted >= 400 && results == accepted && !req0_valid && !req1_valid)) begin
            if (taken0) req0_valid = 1'b0;
            if (taken1) req1_valid = 1'b0;
            taken0 = 1'b0; taken1 = 1'b0;
            if (!req0_valid && accepted < 400 && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1; req0_data = W'(pick_value());
            end
            if (!req1_valid && accepted < 400 && $urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1; req1_data = W'(pick_value());
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (req0_ready && req1_ready) dbl = 1'b1;
            if (req0_ready || req1_ready) begin
                g  = req1_ready;
                eg = (req0_valid && req1_valid) ? !model_last : req1_valid;
                n_cmp++;
                if (g !== eg || (g ? !req1_valid : !req0_valid)) begin
                    n_bad++;
                    $display("FAIL rand_grant: got %0d expected %0d (valids %b%b)", g, eg,
                             req1_valid, req0_valid);
                end
                exp_tag.push_back(g);
                exp_val.push_back(g ? int'(req1_data) : int'(req0_data));
                model_last = g;
                accepted++;
                if (g) taken1 = 1'b1; else taken0 = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_val.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_result: got unexpected result %h expected none", digits());
                end else begin
                    v = exp_val.pop_front();
                    g = exp_tag.pop_front();
                    if (digits() !== ref_bcd(v) || out_tag !== g || out_overflow !== (v > 9999) ||
                        out_blank !== ref_blank(v)) begin
                        n_bad++;
                        $display("FAIL rand_result: value %0d got %h/%b/%b/%b expected %h/%b/%b/%b",
                                 v, digits(), out_tag, out_overflow, out_blank, ref_bcd(v), g,
                                 v > 9999, ref_blank(v));
                    end
                end
                results++;
            end
            cyc();
            cycles++;
        end
        n_cmp++;
        if (accepted < 400 || results != accepted) begin
            n_bad++;
            $display("FAIL rand_complete: got %0d of %0d results expected all of at least 400",
                     results, accepted);
        end
        n_cmp++;
        if (dbl) begin n_bad++; $display("FAIL rand_one_ready: got two readies expected one"); end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0;    req1_data = '0;
        out_ready = 1'b0;
        cyc();
        test_reset();
        test_single();
        test_arbitration();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
